decoder_sequencer: RTL

Registered 2-to-4 one-hot decoder with a valid/ready input handshake and a one-entry pending buffer. Each accepted 2-bit code drives exactly one output line high for HOLD_CYCLES clocks, followed by at least GAP_CYCLES clocks of all-zero output. The block is the decode side of the team's 4-to-2 priority-encoder path and drives select/strobe lines from a code stream.

---
 rtl/decoder_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/decoder_sequencer.sv
// Registered 2-to-4 one-hot decoder with valid/ready intake, a one-entry pending buffer and HOLD/GAP pulse timing.
// Optional even-parity check on intake is enabled by defining DECODER_SEQ_PARITY_EN.
module decoder_sequencer #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_code,
`ifdef DECODER_SEQ_PARITY_EN
  input  logic             in_parity,
  output logic             par_err,
`endif
  output logic [3:0]       out,
  output logic             out_valid,
  output logic             busy,
  output logic [CNT_W-1:0] code_cnt
);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             pend_valid_q, pend_valid_d;
  logic [1:0]       pend_code_q, pend_code_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [3:0]       out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, code_ok, launch;

  function automatic logic [3:0] decode(input logic [1:0] code);
    return 4'b0001 << code;
  endfunction

  assign in_ready  = rst_n && enable && !pend_valid_q;
  assign accept    = in_valid && in_ready;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != IDLE) || pend_valid_q;
  assign code_cnt  = cnt_q;

`ifdef DECODER_SEQ_PARITY_EN
  logic par_err_q;
  assign code_ok = ~^{in_parity, in_code};
  assign par_err = par_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_err_q <= 1'b0;
    else        par_err_q <= accept && !code_ok;
  end
`else
  assign code_ok = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_code_d  = pend_code_q;
    hold_d       = hold_q;
    gap_d        = gap_q;
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    cnt_d        = cnt_q;
    launch       = 1'b0;

    case (state_q)
      IDLE: launch = pend_valid_q && enable;
      DRIVE: begin
        if (hold_q == '0) begin
          if (GAP_CYCLES > 0) begin
            state_d     = GAP;
            out_d       = 4'b0000;
            out_valid_d = 1'b0;
            gap_d       = GAP_LOAD;
          end else if (pend_valid_q && enable) begin
            launch = 1'b1;
          end else begin
            state_d     = IDLE;
            out_d       = 4'b0000;
            out_valid_d = 1'b0;
          end
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          if (pend_valid_q && enable) launch = 1'b1;
          else                        state_d = IDLE;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Launch and intake are mutually exclusive: intake needs an empty pending slot, launch needs a full one.
    if (launch) begin
      state_d      = DRIVE;
      hold_d       = HOLD_LOAD;
      out_d        = decode(pend_code_q);
      out_valid_d  = 1'b1;
      cnt_d        = cnt_q + CNT_W'(1);
      pend_valid_d = 1'b0;
    end
    if (accept && code_ok) begin
      pend_valid_d = 1'b1;
      pend_code_d  = in_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pend_valid_q <= 1'b0;
      pend_code_q  <= 2'b00;
      hold_q       <= '0;
      gap_q        <= '0;
      out_q        <= 4'b0000;
      out_valid_q  <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_code_q  <= pend_code_d;
      hold_q       <= hold_d;
      gap_q        <= gap_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      cnt_q        <= cnt_d;
    end
  end
endmodule
